// File: rtl/shifter_pipe.sv
// shifter_pipe -- two-stage valid/ready operand shifter (LSL/LSR/ASR/ROR/RRX)
// with ARM-style carry-out for both immediate-amount and register-amount forms.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   flush                 sync; clears both stage valids, drops any input beat
//   in_valid / in_ready   input handshake
//   shift_type            00 LSL, 01 LSR, 10 ASR, 11 ROR
//   imm_form              1 = immediate amount, 0 = register amount
//   shift_amt [AMT_W]     shift amount n (full width used in range checks)
//   op_val [WIDTH]        value to shift
//   carry_in              current C flag
//   out_valid / out_ready output handshake
//   result [WIDTH]        shifted value
//   carry_out             shifter carry
//
// Build option: define SHIFTER_RRX_EN to make immediate-form ROR #0 an RRX;
// otherwise that encoding passes op_val and carry_in through unchanged.
module shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       shift_type,
    input  logic             imm_form,
    input  logic [AMT_W-1:0] shift_amt,
    input  logic [WIDTH-1:0] op_val,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);
    localparam int STAGES = 2;
    localparam int LW     = $clog2(WIDTH);
    localparam int SW     = LW + 1;          // holds 0..WIDTH

`ifdef SHIFTER_RRX_EN
    localparam bit RRX_EN = 1'b1;
`else
    localparam bit RRX_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_PASS, OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX
    } op_e;

    // Decoded S1 contents: special cases are already folded into op/amt.
    // For LSL/LSR/ASR amt is clamped to WIDTH and 'over' marks n > WIDTH;
    // for ROR amt is n mod WIDTH.
    typedef struct packed {
        op_e             op;
        logic            over;
        logic [SW-1:0]   amt;
        logic [WIDTH-1:0] val;
        logic            cin;
    } s1_t;

    logic [STAGES:1] vld_pipe;
    s1_t             s1_q, dec;
    logic            s2_ready, s1_ready;
    logic [31:0]     n_ext, n_eff;

    assign s2_ready  = !vld_pipe[2] || out_ready;
    assign s1_ready  = !vld_pipe[1] || s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = vld_pipe[2];

    // ---------------- S1 decode ----------------
    assign n_ext = 32'(shift_amt);

    always_comb begin
        dec     = '0;
        dec.val = op_val;
        dec.cin = carry_in;
        n_eff   = n_ext;
        // Immediate LSR/ASR #0 encodes a shift by WIDTH.
        if (imm_form && n_ext == 0 && (shift_type == 2'b01 || shift_type == 2'b10))
            n_eff = WIDTH;
        case (shift_type)
            2'b00:   dec.op = OP_LSL;
            2'b01:   dec.op = OP_LSR;
            2'b10:   dec.op = OP_ASR;
            default: dec.op = OP_ROR;
        endcase
        if (shift_type == 2'b11) begin
            dec.amt = SW'(shift_amt[LW-1:0]);
        end else begin
            dec.over = (n_eff > WIDTH);
            dec.amt  = dec.over ? SW'(WIDTH) : SW'(n_eff);
        end
        if (n_eff == 0)
            dec.op = (imm_form && shift_type == 2'b11 && RRX_EN) ? OP_RRX : OP_PASS;
    end

    // ---------------- S2 compute ----------------
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] nx_res;
    logic             nx_c;

    always_comb begin
        ext    = '0;
        nx_res = s1_q.val;
        nx_c   = s1_q.cin;
        case (s1_q.op)
            OP_LSL: begin
                // Extra MSB catches the last bit shifted out.
                ext    = {1'b0, s1_q.val} << s1_q.amt;
                nx_res = s1_q.over ? '0   : ext[WIDTH-1:0];
                nx_c   = s1_q.over ? 1'b0 : ext[WIDTH];
            end
            OP_LSR: begin
                ext    = {s1_q.val, 1'b0} >> s1_q.amt;
                nx_res = s1_q.over ? '0   : ext[WIDTH:1];
                nx_c   = s1_q.over ? 1'b0 : ext[0];
            end
            OP_ASR: begin
                // amt clamped to WIDTH already gives the all-sign result.
                ext    = $signed({s1_q.val, 1'b0}) >>> s1_q.amt;
                nx_res = ext[WIDTH:1];
                nx_c   = ext[0];
            end
            OP_ROR: begin
                // amt==0 here means n was a nonzero multiple of WIDTH;
                // the shift by WIDTH on the left term then yields zero.
                nx_res = (s1_q.val >> s1_q.amt) | (s1_q.val << (SW'(WIDTH) - s1_q.amt));
                nx_c   = nx_res[WIDTH-1];
            end
            OP_RRX: begin
                nx_res = {s1_q.cin, s1_q.val[WIDTH-1:1]};
                nx_c   = s1_q.val[0];
            end
            default: ;
        endcase
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            s1_q      <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (flush) begin
            vld_pipe  <= '0;
        end else begin
            if (s2_ready) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    result    <= nx_res;
                    carry_out <= nx_c;
                end
            end
            if (s1_ready) begin
                vld_pipe[1] <= in_valid;
                if (in_valid)
                    s1_q <= dec;
            end
        end
    end
endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe (WIDTH=32, AMT_W=8): shift/carry vectors,
// streaming with backpressure, flush and async reset.
module tb_shifter_pipe;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, imm_form, carry_in;
    logic [1:0]  shift_type;
    logic [7:0]  shift_amt;
    logic [31:0] op_val, result;
    logic        out_valid, out_ready, carry_out;

    int n_chk = 0;
    int n_pass = 0;

    shifter_pipe #(.WIDTH(32), .AMT_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .shift_type(shift_type), .imm_form(imm_form), .shift_amt(shift_amt),
        .op_val(op_val), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [1:0] st, input logic imm, input logic [7:0] amt,
                         input logic [31:0] v, input logic ci);
        shift_type = st; imm_form = imm; shift_amt = amt; op_val = v; carry_in = ci;
    endtask

    // One beat into an empty pipe; result must show two edges later.
    task automatic run1(input string tag, input logic [1:0] st, input logic imm,
                        input logic [7:0] amt, input logic [31:0] v, input logic ci,
                        input logic [31:0] er, input logic ec);
        @(negedge clk);
        drive(st, imm, amt, v, ci);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".vld"}, 64'(out_valid), 64'd1);
        chk({tag, ".res"}, 64'(result), 64'(er));
        chk({tag, ".c"},   64'(carry_out), 64'(ec));
    endtask

    initial begin
        int sent, got;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(2'b00, 1'b0, 8'd0, 32'd0, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("rst.vld", 64'(out_valid), 64'd0);
        chk("rst.res", 64'(result), 64'd0);
        chk("rst.c",   64'(carry_out), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        // Directed shift vectors
        run1("lsl4",     2'b00, 1'b0, 8'd4,   32'h8000000F, 1'b0, 32'h000000F0, 1'b0);
        run1("lsr_imm0", 2'b01, 1'b1, 8'd0,   32'h80000001, 1'b0, 32'h00000000, 1'b1);
        run1("lsr33",    2'b01, 1'b0, 8'd33,  32'h80000001, 1'b0, 32'h00000000, 1'b0);
        run1("asr200",   2'b10, 1'b0, 8'd200, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1);
        run1("ror36",    2'b11, 1'b0, 8'd36,  32'h0000000F, 1'b0, 32'hF0000000, 1'b1);
`ifdef SHIFTER_RRX_EN
        run1("rrx",      2'b11, 1'b1, 8'd0,   32'h00000003, 1'b1, 32'h80000001, 1'b1);
`else
        run1("ror_imm0", 2'b11, 1'b1, 8'd0,   32'h00000003, 1'b1, 32'h00000003, 1'b1);
`endif
        run1("lsl32",    2'b00, 1'b0, 8'd32,  32'h00000001, 1'b0, 32'h00000000, 1'b1);
        run1("ror32",    2'b11, 1'b0, 8'd32,  32'h80000000, 1'b0, 32'h80000000, 1'b1);
        run1("asr4",     2'b10, 1'b0, 8'd4,   32'h80000010, 1'b1, 32'hF8000001, 1'b0);
        run1("reg0",     2'b01, 1'b0, 8'd0,   32'h12345678, 1'b1, 32'h12345678, 1'b1);
        run1("lsl_imm0", 2'b00, 1'b1, 8'd0,   32'h00000005, 1'b1, 32'h00000005, 1'b1);
        run1("lsr31",    2'b01, 1'b0, 8'd31,  32'hC0000000, 1'b0, 32'h00000001, 1'b1);

        // Streaming: beat i = LSL (i+1) by i, out_ready low on cycles 3..5
        @(negedge clk);
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 6);
            drive(2'b00, 1'b0, 8'(sent), 32'(sent + 1), 1'b0);
            #1;
            if (cyc == 3) chk("strm.in_ready_low", 64'(in_ready), 64'd0);
            if (cyc == 4 || cyc == 5) chk("strm.hold", 64'(result), 64'd4);
            if (out_valid && out_ready) begin
                chk($sformatf("strm.beat%0d", got), 64'(result), 64'((got + 1) << got));
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("strm.count", 64'(got), 64'd6);
        @(negedge clk);
        chk("strm.empty", 64'(out_valid), 64'd0);

        // Flush with both stages full, plus a simultaneous input beat
        out_ready = 1'b0; in_valid = 1'b1;
        drive(2'b00, 1'b0, 8'd1, 32'h80000001, 1'b0);
        @(negedge clk); @(negedge clk);
        in_valid = 1'b0; #1;
        chk("full.in_ready", 64'(in_ready), 64'd0);
        chk("full.vld", 64'(out_valid), 64'd1);
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.vld", 64'(out_valid), 64'd0);
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("flush.drop", 64'(out_valid), 64'd0);

        // Async reset with both stages full
        in_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        in_valid = 1'b0; #1;
        chk("prerst.res", 64'(result), 64'd2);
        reset = 1'b1; #1;
        chk("arst.vld", 64'(out_valid), 64'd0);
        chk("arst.res", 64'(result), 64'd0);
        chk("arst.c",   64'(carry_out), 64'd0);
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        chk("arst.vld2", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
